// File: rtl/hex_display_scanner.sv
// ---------------------------------------------------------------------------
// hex_display_scanner
//
// Upstream feeder for a 7-segment decoder.  Holds a DIGITS-digit hex word and
// time-multiplexes it onto one shared segment bus, one digit slot at a time.
// A new word arrives over a valid/ready handshake.  It is parked in a pending
// register and only committed to the display at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN  - when defined, a digit is suppressed if it and all
//                            higher digits are zero and its dp is clear.
//                            Digit 0 is never suppressed.  The nibble output
//                            still carries the value and scan timing is
//                            unchanged.  When undefined, every digit is lit.
//
// Parameters:
//   DIGITS        number of multiplexed digits (2..8)
//   REFRESH_DIV   clk cycles per digit slot (>= BLANK_CYCLES+2)
//   BLANK_CYCLES  cycles at slot start with all anodes off (anti-ghosting)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active high
//   load_valid  in   producer presents load_data/load_dp
//   load_ready  out  scanner can accept a word
//   load_data   in   hex word, digit i = load_data[4i+3:4i], digit 0 rightmost
//   load_dp     in   decimal point per digit, 1 = lit
//   nibble      out  current digit value, to decoder b[3:0]
//   an          out  digit anodes, active low
//   dp_n        out  decimal point, active low
//   digit_idx   out  digit currently scanned
//   frame_tick  out  one-cycle pulse when digit_idx wraps to 0
// ---------------------------------------------------------------------------
module hex_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [4*DIGITS-1:0]        load_data,
    input  logic [DIGITS-1:0]          load_dp,
    output logic [3:0]                 nibble,
    output logic [DIGITS-1:0]          an,
    output logic                       dp_n,
    output logic [$clog2(DIGITS)-1:0]  digit_idx,
    output logic                       frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } load_state_t;

    load_state_t state;

    logic [PW-1:0]            presc;
    logic [PW-1:0]            presc_nxt;
    logic [IW-1:0]            idx_nxt;
    logic                     slot_end;
    logic                     wrap;
    logic                     commit;
    logic                     suppress;
    logic                     lit;

    logic [DIGITS-1:0][3:0]   disp;
    logic [DIGITS-1:0][3:0]   pend;
    logic [DIGITS-1:0][3:0]   disp_nxt;
    logic [DIGITS-1:0]        disp_dp;
    logic [DIGITS-1:0]        pend_dp;
    logic [DIGITS-1:0]        dp_nxt;
    logic [DIGITS-1:0]        an_nxt;

    // Scan timing: the prescaler sweeps one digit slot, and the last slot of
    // the last digit is the frame wrap.  The registered outputs are computed
    // from these next-state values so they line up with presc/digit_idx.
    always_comb begin
        slot_end  = (presc == PRESC_LAST);
        wrap      = slot_end && (digit_idx == IDX_LAST);
        presc_nxt = slot_end ? '0 : presc + PW'(1);
        idx_nxt   = digit_idx;
        if (slot_end) begin
            idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
        end
    end

    // The display contents visible after this edge: a pending word is
    // committed exactly on the wrap edge, so the first slot to show it is
    // digit 0 of the new frame.
    always_comb begin
        commit   = (state == FULL) && wrap;
        disp_nxt = commit ? pend    : disp;
        dp_nxt   = commit ? pend_dp : disp_dp;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;

    // A digit is suppressed while every digit from it upward is zero and its
    // own dp is off.  The walk starts at the top digit and stops before
    // digit 0, which always stays lit.
    always_comb begin
        zero_above = 1'b1;
        suppress   = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (disp_nxt[k] == 4'd0);
            if (idx_nxt == IW'(k)) begin
                suppress = zero_above & ~dp_nxt[k];
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Anode enable for the upcoming slot position: dark during the blanking
    // window at slot start, and dark for the whole slot if suppressed.
    always_comb begin
        lit             = (presc_nxt >= BLANK_END) && !suppress;
        an_nxt          = '1;
        an_nxt[idx_nxt] = ~lit;
    end

    // Scan registers and all display-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
            nibble     <= 4'd0;
            an         <= '1;
            dp_n       <= 1'b1;
        end else begin
            presc      <= presc_nxt;
            digit_idx  <= idx_nxt;
            frame_tick <= wrap;
            nibble     <= disp_nxt[idx_nxt];
            an         <= an_nxt;
            dp_n       <= lit ? ~dp_nxt[idx_nxt] : 1'b1;
        end
    end

    // Load FSM.  EMPTY accepts one word into pending; FULL holds it until
    // the frame wrap moves it into the display.  load_ready is registered,
    // so it is still low on the commit edge and no second word slips in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            load_ready <= 1'b1;
            pend       <= '0;
            pend_dp    <= '0;
            disp       <= '0;
            disp_dp    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load_valid) begin
                        pend       <= load_data;
                        pend_dp    <= load_dp;
                        state      <= FULL;
                        load_ready <= 1'b0;
                    end
                end
                FULL: begin
                    if (wrap) begin
                        disp       <= pend;
                        disp_dp    <= pend_dp;
                        state      <= EMPTY;
                        load_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scanner
//
// Directed self-checking bench for hex_display_scanner with DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2.  Time is tracked as t = number of rising
// edges since reset release, so presc = t%8 and digit = (t/8)%4; all
// expected values below are worked out by hand from that.
// Honours LEADING_ZERO_BLANK_EN to pick the expected anode pattern for
// leading-zero digits.
// ---------------------------------------------------------------------------
module tb_hex_display_scanner;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int t;
    int checks;
    int passes;

    hex_display_scanner #(
        .DIGITS       (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .nibble     (nibble),
        .an         (an),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Advance until the edge count reaches n.
    task automatic stepTo(input int n);
        while (t < n) tick();
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] p);
        load_valid = v;
        load_data  = d;
        load_dp    = p;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s at t=%0d: observed %h expected %h", tag, t, obs, exp);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_an,
                               input logic [3:0] exp_nib, input logic exp_dpn);
        check({tag, ".an"},     16'(an),     16'(exp_an));
        check({tag, ".nibble"}, 16'(nibble), 16'(exp_nib));
        check({tag, ".dp_n"},   16'(dp_n),   16'(exp_dpn));
    endtask

    initial begin
        t      = 0;
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'b0000);

        // Reset values while rst is held.
        #2;
        checkOutput("rst_hold", 4'b1111, 4'h0, 1'b1);
        check("rst_hold.ready", 16'(load_ready), 16'd1);
        check("rst_hold.idx",   16'(digit_idx),  16'd0);
        check("rst_hold.tick",  16'(frame_tick), 16'd0);

        @(negedge clk);
        rst = 1'b0;
        t   = 0;

        // Test 1: blank window, then digit 0 lit, slot and frame timing.
        checkOutput("t1_p0", 4'b1111, 4'h0, 1'b1);
        stepTo(1);
        checkOutput("t1_p1", 4'b1111, 4'h0, 1'b1);
        stepTo(2);
        checkOutput("t1_d0", 4'b1110, 4'h0, 1'b1);
        stepTo(8);
        check("t1_slot1.idx", 16'(digit_idx), 16'd1);
        check("t1_slot1.an",  16'(an),        16'(4'b1111));
        stepTo(10);
        check("t1_d1.an", 16'(an), LZB ? 16'(4'b1111) : 16'(4'b1101));
        stepTo(31);
        check("t1_pre_wrap.tick", 16'(frame_tick), 16'd0);
        check("t1_pre_wrap.idx",  16'(digit_idx),  16'd3);
        stepTo(32);
        check("t1_wrap.tick", 16'(frame_tick), 16'd1);
        check("t1_wrap.idx",  16'(digit_idx),  16'd0);
        stepTo(33);
        check("t1_post_wrap.tick", 16'(frame_tick), 16'd0);

        // Test 2: load 3A7F / dp 0100 mid-frame, transfer at edge 34.
        applyStimulus(1'b1, 16'h3A7F, 4'b0100);
        stepTo(34);
        applyStimulus(1'b0, 16'hFFFF, 4'b1111);
        check("t2_taken.ready", 16'(load_ready), 16'd0);
        checkOutput("t2_old_d0", 4'b1110, 4'h0, 1'b1);

        // Test 3: second word held valid while FULL (edge 65 is the first
        // edge with ready high, right after the wrap at 64).
        stepTo(40);
        applyStimulus(1'b1, 16'h1234, 4'b0001);
        stepTo(50);
        checkOutput("t2_old_d2", LZB ? 4'b1111 : 4'b1011, 4'h0, 1'b1);
        stepTo(63);
        check("t3_full.ready", 16'(load_ready), 16'd0);
        check("t3_old_d3.nibble", 16'(nibble), 16'h0);
        stepTo(64);
        checkOutput("t2_commit", 4'b1111, 4'hF, 1'b1);
        check("t4_commit.ready", 16'(load_ready), 16'd1);
        stepTo(65);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        check("t4_second_taken.ready", 16'(load_ready), 16'd0);
        stepTo(66);
        checkOutput("t2_d0", 4'b1110, 4'hF, 1'b1);
        stepTo(74);
        checkOutput("t2_d1", 4'b1101, 4'h7, 1'b1);
        stepTo(82);
        checkOutput("t2_d2", 4'b1011, 4'hA, 1'b0);
        stepTo(87);
        check("t2_d2_end.dp_n", 16'(dp_n), 16'd0);
        stepTo(90);
        checkOutput("t2_d3", 4'b0111, 4'h3, 1'b1);
        stepTo(96);
        check("t3_commit.ready", 16'(load_ready), 16'd1);
        check("t3_commit.nibble", 16'(nibble), 16'h4);
        stepTo(98);
        checkOutput("t3_d0", 4'b1110, 4'h4, 1'b0);
        stepTo(106);
        checkOutput("t3_d1", 4'b1101, 4'h3, 1'b1);
        stepTo(114);
        checkOutput("t3_d2", 4'b1011, 4'h2, 1'b1);
        stepTo(122);
        checkOutput("t3_d3", 4'b0111, 4'h1, 1'b1);

        // Load accepted on a wrap edge from EMPTY (edge 128): pending only,
        // shown after the next wrap at 160.
        stepTo(127);
        applyStimulus(1'b1, 16'h0050, 4'b0000);
        stepTo(128);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        check("t6_taken.ready", 16'(load_ready), 16'd0);
        stepTo(130);
        checkOutput("t6_old_d0", 4'b1110, 4'h4, 1'b0);
        stepTo(162);
        checkOutput("t6_d0", 4'b1110, 4'h0, 1'b1);
        stepTo(170);
        checkOutput("t6_d1", 4'b1101, 4'h5, 1'b1);
        stepTo(178);
        checkOutput("t6_d2", LZB ? 4'b1111 : 4'b1011, 4'h0, 1'b1);
        stepTo(186);
        checkOutput("t6_d3", LZB ? 4'b1111 : 4'b0111, 4'h0, 1'b1);

        // All-zero word: only digit 0 stays lit with blanking enabled.
        applyStimulus(1'b1, 16'h0000, 4'b0000);
        stepTo(187);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        stepTo(194);
        checkOutput("t6z_d0", 4'b1110, 4'h0, 1'b1);
        stepTo(202);
        checkOutput("t6z_d1", LZB ? 4'b1111 : 4'b1101, 4'h0, 1'b1);

        // Test 5: word pending, then async reset mid-slot.
        stepTo(204);
        applyStimulus(1'b1, 16'hBEEF, 4'b1111);
        stepTo(205);
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        check("t5_pending.ready", 16'(load_ready), 16'd0);
        stepTo(210);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_async", 4'b1111, 4'h0, 1'b1);
        check("t5_async.ready", 16'(load_ready), 16'd1);
        check("t5_async.idx",   16'(digit_idx),  16'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        stepTo(32);
        check("t5_wrap.tick", 16'(frame_tick), 16'd1);
        stepTo(34);
        checkOutput("t5_d0", 4'b1110, 4'h0, 1'b1);
        check("t5_d0.ready", 16'(load_ready), 16'd1);
        stepTo(42);
        checkOutput("t5_d1", LZB ? 4'b1111 : 4'b1101, 4'h0, 1'b1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
